// File: rtl/tt_pkg.sv
// Shared definitions for the time-tag sequencer: tag word layout, FSM states
// and the helper that assembles one 128-bit tag word.
package tt_pkg;

  localparam int TT_W        = 128;
  localparam int MID_W       = 4;
  localparam int BLK_W       = 2;
  localparam int PER_FIELD_W = 115;

  // Field positions, MSB first: frame | single flag | module_id | blk | cmd flag | period
  localparam int FRAME_LSB   = 123;
  localparam int SINGLE_BIT  = 122;
  localparam int MID_LSB     = 118;
  localparam int BLK_LSB     = 116;
  localparam int CMD_BIT     = 115;

  localparam logic [4:0] FRAME = 5'b11111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } seq_state_e;

  // Builds one tag word; single and cmd flags are always 0 for time tags.
  function automatic logic [TT_W-1:0] make_tag(
    input logic [MID_W-1:0]       mid,
    input logic [BLK_W-1:0]       blk,
    input logic [PER_FIELD_W-1:0] per
  );
    make_tag = {FRAME, 1'b0, mid, blk, 1'b0, per};
  endfunction

endpackage

// File: rtl/tt_timer.sv
// Free-running sub-period counter and period counter. period_done marks the
// last cycle of each period; on that cycle the counter wraps and the period
// counter advances (wrapping modulo 2**PERIOD_W).
module tt_timer
  import tt_pkg::*;
#(
  parameter int CLK_PER_TT = 114998,
  parameter int CNT_W      = 17,
  parameter int PERIOD_W   = 48
) (
  input  logic                clk,
  input  logic                rst,
  output logic [CNT_W-1:0]    counter,
  output logic [PERIOD_W-1:0] period,
  output logic                period_done
);

  logic [CNT_W-1:0]    r_counter;
  logic [PERIOD_W-1:0] r_period;
  logic                w_period_done;

  assign w_period_done = (r_counter == CNT_W'(CLK_PER_TT));

  // Advance the sub-period counter; wrap it and bump the period at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= '0;
      r_period  <= '0;
    end else if (w_period_done) begin
      r_counter <= '0;
      r_period  <= r_period + PERIOD_W'(1);
    end else begin
      r_counter <= r_counter + CNT_W'(1);
    end
  end

  assign counter     = r_counter;
  assign period      = r_period;
  assign period_done = w_period_done;

endmodule

// File: rtl/time_tag_sequencer.sv
// Time-tag sequencer top: at every period boundary (and once after reset
// release) emits NUM_BLOCKS tag words over a stall-gated valid/ready
// handshake. A new trigger during a burst restarts it and counts lost tags.
module time_tag_sequencer
  import tt_pkg::*;
#(
  parameter int CLK_PER_TT = 114998,
  parameter int CNT_W      = 17,
  parameter int PERIOD_W   = 48,
  parameter int NUM_BLOCKS = 4,
  parameter int DROP_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          module_id,
  output logic                valid,
  input  logic                ready,
  output logic [127:0]        tt,
  input  logic                stall,
  output logic [CNT_W-1:0]    counter,
  output logic [PERIOD_W-1:0] period,
  output logic                period_done,
  output logic [DROP_W-1:0]   dropped,
  input  logic                clr_dropped
);

  localparam int SUM_W = DROP_W + 3;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  logic [PERIOD_W-1:0] w_period;
  logic                w_period_done;
  logic                r_rst_d;
  logic                w_rst_done;
  logic                w_trigger;
  seq_state_e          r_state;
  logic [1:0]          r_blk;
  logic [PERIOD_W-1:0] r_tperiod;
  logic [PERIOD_W-1:0] w_tperiod_nxt;
  logic [DROP_W-1:0]   r_dropped;
  logic                w_valid_int;
  logic                w_valid;
  logic                w_ack;
  logic                w_last;
  logic [2:0]          w_drop_amt;
  logic [SUM_W-1:0]    w_drop_sum;
  logic [DROP_W-1:0]   w_drop_sat;

  tt_timer #(
    .CLK_PER_TT (CLK_PER_TT),
    .CNT_W      (CNT_W),
    .PERIOD_W   (PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .period      (w_period),
    .period_done (w_period_done)
  );

  // Delayed copy of rst: reads 1 throughout reset, so rst_done fires exactly once after release.
  always_ff @(posedge clk) begin
    r_rst_d <= rst;
  end

  assign w_rst_done  = r_rst_d & ~rst;
  assign w_trigger   = w_period_done | w_rst_done;
  assign w_valid_int = (r_state == ST_EMIT);
  assign w_valid     = w_valid_int & ~stall;
  assign w_ack       = w_valid & ready;
  assign w_last      = (r_blk == 2'(NUM_BLOCKS - 1));

  // A burst tags the period value that is current in its first emitting cycle.
  assign w_tperiod_nxt = w_period_done ? (w_period + PERIOD_W'(1)) : w_period;

  // Tags lost on overrun: those not yet sent, excluding one accepted in the same cycle.
  always_comb begin
    w_drop_amt = 3'd0;
    if (w_valid_int) begin
      w_drop_amt = 3'(NUM_BLOCKS) - {1'b0, r_blk} - {2'b00, w_ack};
    end else begin
      w_drop_amt = 3'd0;
    end
    w_drop_sum = SUM_W'(r_dropped) + SUM_W'(w_drop_amt);
    if (w_drop_sum > DROP_MAX) begin
      w_drop_sat = '1;
    end else begin
      w_drop_sat = w_drop_sum[DROP_W-1:0];
    end
  end

  // Burst FSM: a trigger always (re)starts at block 0; acks step through the blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_blk     <= 2'd0;
      r_tperiod <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state   <= ST_EMIT;
            r_blk     <= 2'd0;
            r_tperiod <= w_tperiod_nxt;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (w_trigger) begin
            r_state   <= ST_EMIT;
            r_blk     <= 2'd0;
            r_tperiod <= w_tperiod_nxt;
          end else if (w_ack) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_blk   <= 2'd0;
            end else begin
              r_blk   <= r_blk + 2'd1;
            end
          end else begin
            r_state   <= ST_EMIT;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_blk     <= 2'd0;
          r_tperiod <= '0;
        end
      endcase
    end
  end

  // Saturating lost-tag counter; a clear beats a simultaneous overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped <= '0;
    end else if (clr_dropped) begin
      r_dropped <= '0;
    end else if (w_trigger && w_valid_int) begin
      r_dropped <= w_drop_sat;
    end else begin
      r_dropped <= r_dropped;
    end
  end

  assign valid       = w_valid;
  assign tt          = w_valid_int ? make_tag(module_id, r_blk, PER_FIELD_W'(r_tperiod)) : '0;
  assign period      = w_period;
  assign period_done = w_period_done;
  assign dropped     = r_dropped;

endmodule
